// File: rtl/imm_ext_neg_unit.sv
// imm_ext_neg_unit: registered dual-path sign extension, negation and zero sum of a decode immediate.
// Optional macro IMM_SELF_CHECK_EN adds a registered path-mismatch/nonzero-sum error flag.
module imm_ext_neg_unit #(
  parameter int IMM_W = 12,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  output logic [XLEN-1:0]  ext_imm,
  output logic [XLEN-1:0]  ext_imm2,
  output logic [XLEN-1:0]  minus_ext_imm,
  output logic [XLEN-1:0]  zero,
  output logic             err
);
  logic [XLEN-1:0] w_ext_a, w_ext_b, w_minus, w_zero;
  assign w_ext_a = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign w_ext_b = $signed({imm, {(XLEN-IMM_W){1'b0}}}) >>> (XLEN-IMM_W);
  assign w_minus = ~w_ext_a + 1'b1;
  assign w_zero  = w_ext_a + w_minus;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      ext_imm       <= '0;
      ext_imm2      <= '0;
      minus_ext_imm <= '0;
      zero          <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ext_imm       <= w_ext_a;
        ext_imm2      <= w_ext_b;
        minus_ext_imm <= w_minus;
        zero          <= w_zero;
      end
    end
  end
`ifdef IMM_SELF_CHECK_EN
  logic r_err;
  logic w_err_next;
  assign w_err_next = in_valid && ((w_ext_a != w_ext_b) || (w_zero != '0));
  always_ff @(posedge clk) begin
    r_err <= rst ? 1'b0 : w_err_next;
  end
  always_ff @(posedge clk) begin
    if (!rst && !r_err) assert (!w_err_next);
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_imm_ext_neg_unit.sv
// tb_imm_ext_neg_unit: directed-vector self-checking bench for imm_ext_neg_unit.
module tb_imm_ext_neg_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] imm = '0;
  logic        out_valid, err;
  logic [31:0] ext_imm, ext_imm2, minus_ext_imm, zero;
  int n_vec = 0;
  int n_bad = 0;

  imm_ext_neg_unit #(.IMM_W(12), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .imm(imm),
    .out_valid(out_valid), .ext_imm(ext_imm), .ext_imm2(ext_imm2),
    .minus_ext_imm(minus_ext_imm), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_ext, input logic [31:0] e_minus);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".ext"}, ext_imm, e_ext);
    chk({tag, ".ext2"}, ext_imm2, e_ext);
    chk({tag, ".minus"}, minus_ext_imm, e_minus);
    chk({tag, ".zero"}, zero, 32'd0);
    chk({tag, ".err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic [31:0] r_ext;
    step;
    step;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.ext", ext_imm, 32'd0);
    chk("rst.ext2", ext_imm2, 32'd0);
    chk("rst.minus", minus_ext_imm, 32'd0);
    chk("rst.zero", zero, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b1; imm = 12'd5;
    step;
    chk_out("imm5", 32'h00000005, 32'hFFFFFFFB);
    imm = 12'd12;
    step;
    chk_out("imm12", 32'h0000000C, 32'hFFFFFFF4);
    imm = 12'hFFB;
    step;
    chk_out("imm-5", 32'hFFFFFFFB, 32'h00000005);
    imm = 12'hFF4;
    step;
    chk_out("imm-12", 32'hFFFFFFF4, 32'h0000000C);
    imm = 12'h539;
    step;
    chk_out("imm1337", 32'h00000539, 32'hFFFFFAC7);
    imm = 12'h81D;
    step;
    chk_out("imm-2019", 32'hFFFFF81D, 32'h000007E3);
    imm = 12'h800;
    step;
    chk_out("imm_min", 32'hFFFFF800, 32'h00000800);
    imm = 12'h7FF;
    step;
    chk_out("imm_max", 32'h000007FF, 32'hFFFFF801);
    imm = 12'h000;
    step;
    chk_out("imm0", 32'h00000000, 32'h00000000);
    imm = 12'h123;
    step;
    chk_out("imm291", 32'h00000123, 32'hFFFFFEDD);
    in_valid = 1'b0; imm = 12'hABC;
    step;
    chk("hold.valid", {31'd0, out_valid}, 32'd0);
    chk("hold.ext", ext_imm, 32'h00000123);
    chk("hold.ext2", ext_imm2, 32'h00000123);
    chk("hold.minus", minus_ext_imm, 32'hFFFFFEDD);
    step;
    chk("hold2.ext", ext_imm, 32'h00000123);
    in_valid = 1'b1; imm = 12'h456; rst = 1'b1;
    step;
    chk("rst2.valid", {31'd0, out_valid}, 32'd0);
    chk("rst2.ext", ext_imm, 32'd0);
    chk("rst2.ext2", ext_imm2, 32'd0);
    chk("rst2.minus", minus_ext_imm, 32'd0);
    chk("rst2.zero", zero, 32'd0);
    chk("rst2.err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      imm = 12'(i);
      step;
      r_ext = (i >= 2048) ? 32'(i - 4096) : 32'(i);
      chk_out($sformatf("sweep%0d", i), r_ext, 32'd0 - r_ext);
    end
    in_valid = 1'b0;
    step;
    chk("end.valid", {31'd0, out_valid}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
